// File: rtl/ram_march_tester.sv
// ============================================================================
// Module   : ram_march_tester
// Brief    : March C- test initiator for a 64 x 8 registered-address RAM.
//            Optional MARCH_STOP_ON_FAIL_EN ends the run at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_march_tester #(
  parameter int            AW = 6,
  parameter int            DW = 8,
  parameter logic [DW-1:0] BG = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [2:0]    fail_elem,
  output logic          ram_write_en,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_M0   = 3'd1;
  localparam logic [2:0] ST_M1   = 3'd2;
  localparam logic [2:0] ST_M2   = 3'd3;
  localparam logic [2:0] ST_M3   = 3'd4;
  localparam logic [2:0] ST_M4   = 3'd5;
  localparam logic [2:0] ST_M5   = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    err_q, err_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic [2:0]    fail_elem_q, fail_elem_d;

  logic          w_active;
  logic          w_rw_elem;
  logic          w_down;
  logic          w_next_down;
  logic [AW-1:0] w_last_addr;
  logic [DW-1:0] w_exp;
  logic [DW-1:0] w_wdata;
  logic          w_check;
  logic          w_mismatch;
  logic          w_elem_end;

  assign w_active    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign w_rw_elem   = (state_q >= ST_M1) && (state_q <= ST_M4);
  assign w_down      = (state_q == ST_M3) || (state_q == ST_M4);
  assign w_next_down = (state_q == ST_M2) || (state_q == ST_M3);
  assign w_last_addr = w_down ? '0 : '1;
  assign w_check     = phase_q && (state_q >= ST_M1) && (state_q <= ST_M5);
  assign w_mismatch  = w_check && (ram_data_out != w_exp);
  assign w_elem_end  = ((state_q == ST_M0) || w_check) && (addr_q == w_last_addr);

  // "0" is BG and "1" is ~BG; odd-numbered elements read 0 and write 1.
  always_comb begin
    w_exp   = BG;
    w_wdata = BG;
    case (state_q)
      ST_M1, ST_M3: w_wdata = ~BG;
      ST_M2, ST_M4: w_exp   = ~BG;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;

    if (!w_active) begin
      if (start) begin
        state_d     = ST_M0;
        phase_d     = 1'b0;
        addr_d      = '0;
        err_d       = '0;
        pass_d      = 1'b0;
        fail_addr_d = '0;
        fail_data_d = '0;
        fail_elem_d = '0;
      end
    end else if (state_q == ST_M0) begin
      if (w_elem_end) begin
        state_d = ST_M1;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end else if (!phase_q) begin
      phase_d = 1'b1;
    end else begin
      phase_d = 1'b0;
      if (w_elem_end) begin
        state_d = state_q + 3'd1;
        addr_d  = {AW{w_next_down}};
        if (state_q == ST_M5) begin
          pass_d = (err_q == 8'd0) && !w_mismatch;
        end
      end else begin
        addr_d = w_down ? addr_q - AW'(1) : addr_q + AW'(1);
      end
    end

    if (w_mismatch) begin
      err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      if (err_q == 8'd0) begin
        fail_addr_d = addr_q;
        fail_data_d = ram_data_out;
        fail_elem_d = state_q - 3'd1;
      end
`ifdef MARCH_STOP_ON_FAIL_EN
      state_d = ST_DONE;
      phase_d = 1'b0;
      addr_d  = '0;
      pass_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign busy         = w_active;
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_addr    = fail_addr_q;
  assign fail_data    = fail_data_q;
  assign fail_elem    = fail_elem_q;
  assign ram_write_en = (state_q == ST_M0) || (phase_q && w_rw_elem);
  assign ram_address  = w_active ? addr_q : '0;
  assign ram_data_in  = ram_write_en ? w_wdata : '0;

endmodule

`default_nettype wire

// File: doc/ram_march_tester.md
# ram_march_tester

- Self-contained test initiator for the 64 x 8 single-port RAM.
- Drives the RAM's write-enable, address and write-data inputs, and reads back its registered-address read data.
- Runs a March C- sequence across all locations and reports pass/fail, the first failing location and an error count.
- Sits beside the RAM at bring-up and production test, owning the RAM port while `busy` is high.

## Interface
Parameters:
- `AW`, 6, address width; depth is 2^AW = 64.
- `DW`, 8, data width.
- `BG`, 8'h00, background pattern; "0" = `BG`, "1" = `~BG`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE or DONE.
- `busy` out 1: test in progress.
- `done` out 1: level, high in DONE until next `start` or `rst`.
- `pass` out 1: valid when `done`; 1 = zero mismatches.
- `err_count` out 8: mismatches, saturating at 255.
- `fail_addr` out AW: address of first mismatch.
- `fail_data` out DW: data read at first mismatch.
- `fail_elem` out 3: march element (1..5) of first mismatch.
- `ram_write_en` out 1: to RAM write_en.
- `ram_address` out AW: to RAM address.
- `ram_data_in` out DW: to RAM data_in.
- `ram_data_out` in DW: from RAM data_out.

## Operation
- RAM port contract:
  - Write occurs at the edge where `ram_write_en`=1.
  - A cycle with `ram_write_en`=0 latches the address.
  - `ram_data_out` then reflects that location and is sampled at the following edge.
- March elements, where ⇑ = address 0→63 and ⇓ = 63→0:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DONE.
- Phase bit in M1–M5:
  - ISSUE: `ram_write_en`=0, `ram_address`=a.
  - CHECK: compare `ram_data_out` to the expected value at the edge ending the cycle.
    - In M1–M4 the CHECK cycle also drives `ram_write_en`=1, `ram_address`=a, `ram_data_in`=new value. Read and write of a cell therefore take 2 cycles.
    - M5 CHECK keeps `ram_write_en`=0.
- M0: one write per cycle.
- Address counter is AW bits.
  - An element ends on the CHECK (or M0 write) of address 63 (⇑) or 0 (⇓).
  - On that cycle the counter loads the next element's start address; no wrap-through.
- Mismatch handling:
  - `err_count` increments, saturating at 255.
  - On the first mismatch only, `fail_addr`, `fail_data` and `fail_elem` are captured.
- Transitions:
  - IDLE/DONE with `start`=1 → M0. This clears `err_count`, the fail registers and `pass`.
  - M5 last CHECK → DONE. `pass` is set to (`err_count`==0, including the final compare).
- `start` while `busy` is ignored.
- Outside M0–M5 the RAM outputs are `ram_write_en`=0, `ram_address`=0, `ram_data_in`=0.

## Timing
- Cycle k = k-th cycle after the edge sampling `start`.
- `busy`=1 for cycles 1..704.
- Element cycle ranges:
  - M0: cycles 1–64.
  - M1: 65–192.
  - M2: 193–320.
  - M3: 321–448.
  - M4: 449–576.
  - M5: 577–704.
- Within M1–M5, address a is the i-th address of the element's order (i from 0):
  - ISSUE cycle = element start + 2i.
  - CHECK cycle = element start + 2i + 1.
- `done`=1 and `pass` are valid from cycle 705.
- Reset values: `busy`, `done`, `pass`, `ram_write_en` = 0; `ram_address`, `ram_data_in`, `err_count`, `fail_addr`, `fail_data`, `fail_elem` = 0; state IDLE.
- `rst` mid-run:
  - Next cycle: all outputs at reset values, state IDLE.
  - RAM contents are left as-is.
  - Any in-progress write completes only if it was at that same edge.
- Simultaneous `rst` and `start`: `rst` wins.

## Configuration
- `MARCH_STOP_ON_FAIL_EN` defined:
  - The first mismatch moves the FSM directly to DONE at that edge. The CHECK-cycle write at that edge still lands in the RAM.
  - `done`=1 and `pass`=0 from the next cycle; `err_count`=1.
- Undefined: the full sequence always runs; `err_count` accumulates all mismatches.

## Test plan
- Fault-free RAM model, `BG`=00, `start` pulse:
  - Writes of 00/FF are observed in order.
  - `done` rises at cycle 705 with `pass`=1, `err_count`=0.
- Bit 3 of address 0x2A stuck at 1, macro undefined:
  - `pass`=0, `err_count`=3 (M1, M3, M5).
  - `fail_addr`=0x2A, `fail_data`=0x08, `fail_elem`=1.
- Same fault, `MARCH_STOP_ON_FAIL_EN` defined:
  - Mismatch at cycle 150 (M1 CHECK of 0x2A).
  - `done`=1, `pass`=0, `err_count`=1 at cycle 151.
- `rst` asserted at cycle 300:
  - Cycle 301 shows all reset values.
  - A new `start` completes normally with `pass`=1.
- `start` pulsed at cycle 50 during a run: no effect, `done` still at 705. Second `start` in DONE clears results and reruns.
- `BG`=8'h55: M0 writes 0x55, M1 writes 0xAA, fault-free `pass`=1.
